// File: rtl/proc_io_pkg.sv
// Shared constants and helpers for the processor I/O server.
// Port count and data widths match the float processor's I/O decoder.
package proc_io_pkg;

  localparam int NPORT      = 4;
  localparam int NBIN       = 19;
  localparam int NBOUT      = 28;
  localparam int ODEPTH_DEF = 8;
  localparam int PORTW      = $clog2(NPORT);

  typedef struct packed {
    logic             valid;
    logic [PORTW-1:0] idx;
  } sel_t;

  // An illegal multi-hot vector resolves to its lowest set bit.
  function automatic sel_t onehot_lowest(input logic [NPORT-1:0] vec);
    sel_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = PORTW'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with registered storage and zero-latency head read.
// A push against a full FIFO is accepted only when a pop happens in the same cycle.
module io_fifo
  import proc_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head reads as zero while empty so stale storage never leaks out.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/proc_io_server.sv
// Host-side server for the float processor's I/O ports: per-port input
// mailboxes feeding io_in, and a tagged FIFO capturing io_out strobes.
module proc_io_server
  import proc_io_pkg::*;
#(
  parameter int ODEPTH = ODEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [NBIN-1:0]  io_in,
  input  logic [NPORT-1:0] req_in,
  input  logic [NBOUT-1:0] io_out,
  input  logic [NPORT-1:0] out_en,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PORTW-1:0] s_port,
  input  logic [NBIN-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PORTW-1:0] m_port,
  output logic [NBOUT-1:0] m_data,
  output logic [NPORT-1:0] uf_flag,
  output logic             of_flag,
  input  logic             clr_flags
);

  localparam int FW = PORTW + NBOUT;

  logic [NBIN-1:0]  mb_data [NPORT];
  logic [NPORT-1:0] mb_full;
  logic [NPORT-1:0] mb_pop;
  logic [NPORT-1:0] mb_push;
  logic [NPORT-1:0] uf_set;
  sel_t             req_sel;
  sel_t             out_sel;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_head;
  logic             of_set;

  always_comb begin
    req_sel = onehot_lowest(req_in);
    out_sel = onehot_lowest(out_en);
  end

  // The processor samples io_in in the same cycle it raises req_in.
  assign io_in   = (req_sel.valid && mb_full[req_sel.idx]) ? mb_data[req_sel.idx] : '0;
  assign s_ready = ~mb_full[s_port] | req_in[s_port];

  always_comb begin
    mb_pop  = '0;
    mb_push = '0;
    if (req_sel.valid)      mb_pop[req_sel.idx] = 1'b1;
    if (s_valid && s_ready) mb_push[s_port]     = 1'b1;
  end

  assign uf_set = mb_pop & ~mb_full;

  // Push is applied after pop so a same-port push/pop leaves the mailbox full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mb_full <= '0;
    end else begin
      mb_full <= (mb_full & ~mb_pop) | mb_push;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NPORT; k++) begin
      if (mb_push[k]) mb_data[k] <= s_data;
    end
  end

  assign m_valid   = ~fifo_empty;
  assign fifo_pop  = m_valid & m_ready;
  assign fifo_push = out_sel.valid & (~fifo_full | fifo_pop);
  assign of_set    = out_sel.valid & fifo_full & ~fifo_pop;

  io_fifo #(
    .WIDTH (FW),
    .DEPTH (ODEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({out_sel.idx, io_out}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign {m_port, m_data} = fifo_head;

  // A set event in the clearing cycle takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uf_flag <= '0;
      of_flag <= 1'b0;
    end else begin
      uf_flag <= (clr_flags ? '0 : uf_flag) | uf_set;
      of_flag <= (of_flag & ~clr_flags) | of_set;
    end
  end

endmodule

// File: tb/tb_proc_io_server.sv
// Bench for proc_io_server: directed scenarios plus random traffic against
// a queue/array reference model of the mailboxes, output FIFO and flags.
module tb_proc_io_server;

  localparam int NPORT  = 4;
  localparam int NBIN   = 19;
  localparam int NBOUT  = 28;
  localparam int ODEPTH = 8;
  localparam int PORTW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NBIN-1:0]  io_in;
  logic [NPORT-1:0] req_in;
  logic [NBOUT-1:0] io_out;
  logic [NPORT-1:0] out_en;
  logic             s_valid;
  logic             s_ready;
  logic [PORTW-1:0] s_port;
  logic [NBIN-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PORTW-1:0] m_port;
  logic [NBOUT-1:0] m_data;
  logic [NPORT-1:0] uf_flag;
  logic             of_flag;
  logic             clr_flags;

  int errors = 0;
  int checks = 0;

  proc_io_server #(.ODEPTH(ODEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_in     (io_in),
    .req_in    (req_in),
    .io_out    (io_out),
    .out_en    (out_en),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_port    (s_port),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_port    (m_port),
    .m_data    (m_data),
    .uf_flag   (uf_flag),
    .of_flag   (of_flag),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  // Reference model
  typedef struct packed {
    logic [PORTW-1:0] port;
    logic [NBOUT-1:0] data;
  } ent_t;

  bit               mdl_full [NPORT];
  logic [NBIN-1:0]  mdl_mb   [NPORT];
  ent_t             mdl_q [$];
  logic [NPORT-1:0] mdl_uf;
  logic             mdl_of;

  function automatic int lowest(input logic [NPORT-1:0] v);
    for (int i = 0; i < NPORT; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NBIN-1:0] exp_io_in();
    int k = lowest(req_in);
    if (k < 0) return '0;
    if (!mdl_full[k]) return '0;
    return mdl_mb[k];
  endfunction

  function automatic logic exp_s_ready();
    return !mdl_full[s_port] || req_in[s_port];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NPORT; i++) begin
      mdl_full[i] = 1'b0;
      mdl_mb[i]   = '0;
    end
    mdl_q.delete();
    mdl_uf = '0;
    mdl_of = 1'b0;
  endtask

  task automatic model_step();
    int               rk       = lowest(req_in);
    int               ok       = lowest(out_en);
    bit               was_full = (mdl_q.size() == ODEPTH);
    bit               pop_out  = (mdl_q.size() > 0) && m_ready;
    bit               push_in  = s_valid && exp_s_ready();
    logic [NPORT-1:0] ufs      = '0;
    bit               ofs      = 1'b0;
    if (pop_out) mdl_q.delete(0);
    if (ok >= 0) begin
      if (!was_full || pop_out) mdl_q.push_back('{PORTW'(ok), io_out});
      else ofs = 1'b1;
    end
    if (rk >= 0) begin
      if (!mdl_full[rk]) ufs[rk] = 1'b1;
      mdl_full[rk] = 1'b0;
    end
    if (push_in) begin
      mdl_full[s_port] = 1'b1;
      mdl_mb[s_port]   = s_data;
    end
    mdl_uf = (clr_flags ? '0 : mdl_uf) | ufs;
    mdl_of = (clr_flags ? 1'b0 : mdl_of) | ofs;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    req_in    = '0;
    out_en    = '0;
    io_out    = '0;
    s_valid   = 1'b0;
    s_port    = '0;
    s_data    = '0;
    m_ready   = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (io_in !== '0) begin errors++; $display("FAIL reset_io_in got=%h exp=0", io_in); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_port !== '0 || m_data !== '0) begin errors++; $display("FAIL reset_m_head got=%0d/%h exp=0/0", m_port, m_data); end
    checks++; if (uf_flag !== '0 || of_flag !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b/%b exp=0000/0", uf_flag, of_flag); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mailbox_basic();
    logic [NBIN-1:0] exp;
    exp = NBIN'(-5);
    s_valid = 1'b1; s_port = 2'd2; s_data = exp;
    tick();
    s_valid = 1'b0; req_in = 4'b0100;
    #1;
    checks++; if (io_in !== exp) begin errors++; $display("FAIL mb_serve got=%h exp=%h", io_in, exp); end
    tick();
    req_in = '0; s_port = 2'd2;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mb_empty_after_pop got=%b exp=1", s_ready); end
    checks++; if (uf_flag !== '0) begin errors++; $display("FAIL mb_no_uf got=%b exp=0000", uf_flag); end
  endtask

  task automatic test_underflow_clear();
    req_in = 4'b0001;
    #1;
    checks++; if (io_in !== '0) begin errors++; $display("FAIL uf_io_in got=%h exp=0", io_in); end
    tick();
    req_in = '0;
    #1;
    checks++; if (uf_flag !== 4'b0001) begin errors++; $display("FAIL uf_set got=%b exp=0001", uf_flag); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    #1;
    checks++; if (uf_flag !== '0) begin errors++; $display("FAIL uf_clear got=%b exp=0000", uf_flag); end
  endtask

  task automatic test_push_pop_same();
    s_valid = 1'b1; s_port = 2'd1; s_data = NBIN'(7);
    tick();
    s_data = NBIN'(9); req_in = 4'b0010;
    #1;
    checks++; if (io_in !== NBIN'(7)) begin errors++; $display("FAIL same_io_in got=%h exp=7", io_in); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL same_s_ready got=%b exp=1", s_ready); end
    tick();
    s_valid = 1'b0;
    #1;
    checks++; if (io_in !== NBIN'(9)) begin errors++; $display("FAIL same_new_data got=%h exp=9", io_in); end
    tick();
    req_in = '0;
    #1;
    checks++; if (uf_flag !== '0) begin errors++; $display("FAIL same_no_uf got=%b exp=0000", uf_flag); end
  endtask

  task automatic test_fifo_full_drop();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_en = NPORT'(1 << (i % 4)); io_out = NBOUT'(100 + i);
      tick();
    end
    out_en = 4'b1000; io_out = NBOUT'(999);
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== NBOUT'(100)) begin errors++; $display("FAIL full_head got=%b/%0d exp=1/100", m_valid, m_data); end
    tick();
    out_en = '0;
    #1;
    checks++; if (of_flag !== 1'b1) begin errors++; $display("FAIL of_set got=%b exp=1", of_flag); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_port !== PORTW'(i % 4) || m_data !== NBOUT'(100 + i)) begin
        errors++;
        $display("FAIL drain_%0d got=%b/%0d/%0d exp=1/%0d/%0d", i, m_valid, m_port, m_data, i % 4, 100 + i);
      end
      tick();
    end
    m_ready = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", m_valid); end
  endtask

  task automatic test_full_push_pop();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    for (int i = 0; i < 8; i++) begin
      out_en = NPORT'(1 << (i % 4)); io_out = NBOUT'(200 + i);
      tick();
    end
    out_en = 4'b1000; io_out = NBOUT'(-1); m_ready = 1'b1;
    tick();
    out_en = '0; m_ready = 1'b0;
    #1;
    checks++; if (of_flag !== 1'b0) begin errors++; $display("FAIL pp_no_of got=%b exp=0", of_flag); end
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [PORTW-1:0] ep;
      logic [NBOUT-1:0] ed;
      ep = (i == 8) ? PORTW'(3) : PORTW'(i % 4);
      ed = (i == 8) ? NBOUT'(-1) : NBOUT'(200 + i);
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_port !== ep || m_data !== ed) begin
        errors++;
        $display("FAIL pp_drain_%0d got=%b/%0d/%h exp=1/%0d/%h", i, m_valid, m_port, m_data, ep, ed);
      end
      tick();
    end
    m_ready = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pp_count got=%b exp=0", m_valid); end
  endtask

  function automatic logic [NPORT-1:0] rand_vec();
    int r = $urandom_range(0, 9);
    if (r < 4) return '0;
    if (r < 9) return NPORT'(1 << $urandom_range(0, NPORT - 1));
    return NPORT'($urandom);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      s_valid   = $urandom_range(0, 1);
      s_port    = PORTW'($urandom);
      s_data    = NBIN'($urandom);
      req_in    = rand_vec();
      out_en    = rand_vec();
      io_out    = NBOUT'($urandom);
      m_ready   = (c < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr_flags = ($urandom_range(0, 15) == 0);
      #1;
      checks++; if (io_in !== exp_io_in()) begin errors++; $display("FAIL rnd_io_in c=%0d got=%h exp=%h", c, io_in, exp_io_in()); end
      checks++; if (s_ready !== exp_s_ready()) begin errors++; $display("FAIL rnd_s_ready c=%0d got=%b exp=%b", c, s_ready, exp_s_ready()); end
      checks++; if (m_valid !== (mdl_q.size() > 0)) begin errors++; $display("FAIL rnd_m_valid c=%0d got=%b exp=%0d", c, m_valid, mdl_q.size()); end
      if (mdl_q.size() > 0) begin
        checks++;
        if (m_port !== mdl_q[0].port || m_data !== mdl_q[0].data) begin
          errors++;
          $display("FAIL rnd_head c=%0d got=%0d/%h exp=%0d/%h", c, m_port, m_data, mdl_q[0].port, mdl_q[0].data);
        end
      end
      checks++; if (uf_flag !== mdl_uf || of_flag !== mdl_of) begin errors++; $display("FAIL rnd_flags c=%0d got=%b/%b exp=%b/%b", c, uf_flag, of_flag, mdl_uf, mdl_of); end
      tick();
    end
    idle();
  endtask

  task automatic test_midreset();
    s_valid = 1'b1; s_port = 2'd0; s_data = NBIN'(11); req_in = 4'b0010;
    tick();
    s_valid = 1'b0; req_in = '0; out_en = 4'b0001; io_out = NBOUT'(5);
    tick();
    out_en = '0; req_in = 4'b0001;
    #1;
    checks++; if (io_in !== exp_io_in()) begin errors++; $display("FAIL mr_before got=%h exp=%h", io_in, exp_io_in()); end
    rst = 1'b0;
    #1;
    checks++; if (io_in !== '0) begin errors++; $display("FAIL mr_io_in got=%h exp=0", io_in); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_m_valid got=%b exp=0", m_valid); end
    checks++; if (uf_flag !== '0 || of_flag !== 1'b0) begin errors++; $display("FAIL mr_flags got=%b/%b exp=0000/0", uf_flag, of_flag); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (io_in !== '0) begin errors++; $display("FAIL mr_discard got=%h exp=0", io_in); end
    tick();
    req_in = '0;
    #1;
    checks++; if (uf_flag !== 4'b0001) begin errors++; $display("FAIL mr_uf got=%b exp=0001", uf_flag); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mailbox_basic();
    test_underflow_clear();
    test_push_pop_same();
    test_fifo_full_drop();
    test_full_push_pop();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_io_server.md
Name: proc_io_server

Overview:
- Host-side counterpart of the float processor's I/O port interface. Serves the processor's decoded one-hot input requests (req_in) from per-port mailboxes. Captures its one-hot output strobes (out_en, with io_out) into a tagged output FIFO.
- Sits between the processor top level and a testbench or host stream. The host pushes tagged 19-bit integer samples in and pops tagged 28-bit results out with valid/ready.

Parameters:
- NPORT, 4, number of processor I/O ports; equals width of req_in/out_en.
- NBIN, 19, width of io_in sample (signed integer fed to int2float).
- NBOUT, 28, width of io_out result (signed integer from float2int).
- ODEPTH, 8, output FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- io_in  out  NBIN  sample presented to processor (signed).
- req_in  in  NPORT  one-hot input request from processor decoder.
- io_out  in  NBOUT  result from processor (signed).
- out_en  in  NPORT  one-hot output strobe from processor decoder.
- s_valid  in  1  host sample valid.
- s_ready  out  1  host sample accepted when s_valid&s_ready.
- s_port  in  log2(NPORT)  target input port of sample.
- s_data  in  NBIN  sample value.
- m_valid  out  1  result available.
- m_ready  in  1  host consumes result when m_valid&m_ready.
- m_port  out  log2(NPORT)  port the result was written to.
- m_data  out  NBOUT  result value.
- uf_flag  out  NPORT  sticky: req_in[k] seen with mailbox k empty.
- of_flag  out  1  sticky: out_en seen with output FIFO full (result dropped).
- clr_flags  in  1  synchronous clear of uf_flag/of_flag.

Behaviour:
- Reset (rst=0, async):
  - all mailboxes empty, output FIFO empty.
  - io_in=0, s_ready=1, m_valid=0, m_port=0, m_data=0, uf_flag=0, of_flag=0.
  - Mid-operation reset discards all stored data immediately.
- Mailboxes: one NBIN register plus full bit per port.
- Input side:
  - io_in is combinational: mailbox data of the asserted req_in bit, or 0 if none asserted or that mailbox is empty. Processor samples io_in in the same cycle it asserts req_in.
  - On a clock edge with req_in[k]=1: mailbox k is popped (full←0). If it was empty, uf_flag[k]←1 and io_in was 0.
  - req_in multi-hot (illegal): lowest set index serves and pops; other bits are ignored with no pop. uf_flag is not set for the ignored bits.
  - s_ready = ~full[s_port] | req_in[s_port]; push and pop of the same port in one cycle is allowed, and the mailbox stays full with the new data.
  - Push: full[s_port]←1, data←s_data. Zero-latency bypass is not provided; a pushed sample is visible on io_in from the next cycle.
- Output side: synchronous FIFO, ODEPTH entries of {port, data}.
  - On out_en[k]=1: push {k, io_out} if not full, or if full and popping this cycle. Otherwise drop and set of_flag←1.
  - out_en multi-hot: lowest set index is tagged, single push.
  - m_valid = FIFO not empty; m_port/m_data = head entry, registered storage, zero-latency read from head.
  - Pop on m_valid&m_ready. Simultaneous push and pop at full: both occur and the count is unchanged. Pop at empty: ignored.
  - Pointers wrap modulo ODEPTH. Count width is log2(ODEPTH)+1.
- Flags:
  - clr_flags clears sticky flags.
  - A set event in the same cycle as clr_flags wins (flag ends 1).
- No arithmetic on data: values pass bit-exact, sign preserved.

Decomposition:
- Package proc_io_pkg: NPORT, NBIN, NBOUT defaults; PORTW=log2(NPORT); function onehot_lowest(vec) returning index and valid.
- Sub-module io_fifo (param WIDTH, DEPTH): sync FIFO with push/pop/full/empty/head. Instantiated once with WIDTH=PORTW+NBOUT.
- Mailboxes and flag logic stay in the top.

Test Plan:
- Reset then push port 2 sample -5, next cycle req_in=4'b0100 → io_in=-5 that cycle. Mailbox 2 is empty after, and uf_flag stays 0.
- req_in=4'b0001 with mailbox 0 empty → io_in=0, uf_flag=4'b0001. clr_flags pulse → uf_flag=0.
- Mailbox 1 full (value 7), s_valid with s_port=1, s_data=9 and req_in=4'b0010 in the same cycle → io_in=7, s_ready=1. Next cycle io_in=9 on req_in=4'b0010.
- Eight out_en pulses (ports 0..3 cycling, io_out=100..107) with m_ready=0 → FIFO full. A ninth pulse is dropped and of_flag=1. Draining gives ports 0,1,2,3,0,1,2,3 with data 100..107 in order.
- FIFO full, out_en=4'b1000 io_out=-1 and m_ready=1 in the same cycle → head popped, {3,-1} stored, of_flag stays 0, count stays 8.
- Assert rst low mid-stream with mailboxes and FIFO non-empty → m_valid=0, io_in=0, flags 0 immediately. After release, req_in gives uf_flag set.
